// File: rtl/decode_stage_if.sv
// Fetch/writeback/execute-side bundle for decode_stage. The master side drives
// the instruction, control and writeback inputs; the slave (decode) side drives stall and ID/EX.
interface decode_stage_if #(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned ADDRESSWIDTH     = 4,
    parameter int unsigned OPCODEWIDTH      = 4,
    parameter int unsigned INSTRUCTIONWIDTH = 16
);
    logic                        instrValid;
    logic [INSTRUCTIONWIDTH-1:0] instruction;
    logic                        flush;
    logic                        holdIn;
    logic                        writeEnable;
    logic [ADDRESSWIDTH-1:0]     writeAddress;
    logic [WIDTH-1:0]            dataToSave;
    logic                        stallOut;
    logic                        exValid;
    logic [OPCODEWIDTH-1:0]      exOpcode;
    logic [WIDTH-1:0]            exReg1Content;
    logic [WIDTH-1:0]            exReg2Content;
    logic [WIDTH-1:0]            exInmediate;
    logic [ADDRESSWIDTH-1:0]     exReg1Address;
    logic [ADDRESSWIDTH-1:0]     exReg2Address;
    logic [ADDRESSWIDTH-1:0]     exDestAddress;

    modport master (
        output instrValid, instruction, flush, holdIn, writeEnable, writeAddress, dataToSave,
        input  stallOut, exValid, exOpcode, exReg1Content, exReg2Content, exInmediate,
               exReg1Address, exReg2Address, exDestAddress
    );

    modport slave (
        input  instrValid, instruction, flush, holdIn, writeEnable, writeAddress, dataToSave,
        output stallOut, exValid, exOpcode, exReg1Content, exReg2Content, exInmediate,
               exReg1Address, exReg2Address, exDestAddress
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: field extract, bypassed register file, load-use bubble, ID/EX register.
// Define DECODE_SIGNEXT_EN to sign-extend the immediate; otherwise it is zero-extended.
module decode_stage #(
    parameter int unsigned          WIDTH            = 8,
    parameter int unsigned          REGNUM           = 16,
    parameter int unsigned          ADDRESSWIDTH     = 4,
    parameter int unsigned          OPCODEWIDTH      = 4,
    parameter int unsigned          INSTRUCTIONWIDTH = 16,
    parameter int unsigned          IMMWIDTH         = 8,
    parameter logic [OPCODEWIDTH-1:0] LOADOPCODE     = 4'h9
) (
    input  logic          clock,
    input  logic          reset,
    decode_stage_if.slave bus
);
    localparam int unsigned AW = ADDRESSWIDTH;
    localparam int unsigned OW = OPCODEWIDTH;
    localparam int unsigned IW = INSTRUCTIONWIDTH;

    typedef struct packed {
        logic             valid;
        logic [OW-1:0]    opcode;
        logic [WIDTH-1:0] r1_data;
        logic [WIDTH-1:0] r2_data;
        logic [WIDTH-1:0] imm;
        logic [AW-1:0]    r1_addr;
        logic [AW-1:0]    r2_addr;
        logic [AW-1:0]    rd_addr;
    } idex_t;

    logic [WIDTH-1:0] regs_q [REGNUM];
    logic [WIDTH-1:0] regs_d [REGNUM];
    idex_t            idex_q;
    idex_t            idex_d;

    logic [AW-1:0]       r1;
    logic [AW-1:0]       r2;
    logic [AW-1:0]       rd;
    logic [OW-1:0]       opcode;
    logic [IMMWIDTH-1:0] imm_raw;
    logic [WIDTH-1:0]    imm_ext;
    logic [WIDTH-1:0]    r1_data;
    logic [WIDTH-1:0]    r2_data;
    logic                wr_hit;
    logic                hazard;

    always_comb begin
        r1      = bus.instruction[AW-1:0];
        r2      = bus.instruction[2*AW-1:AW];
        rd      = bus.instruction[3*AW-1:2*AW];
        opcode  = bus.instruction[IW-1 -: OW];
        imm_raw = bus.instruction[IMMWIDTH-1:0];
`ifdef DECODE_SIGNEXT_EN
        imm_ext = WIDTH'($signed(imm_raw));
`else
        imm_ext = WIDTH'(imm_raw);
`endif
    end

    // Bypass only forwards writes that actually land, so out-of-range addresses always read 0.
    always_comb begin
        wr_hit  = bus.writeEnable && (32'(bus.writeAddress) < REGNUM);
        r1_data = (wr_hit && bus.writeAddress == r1) ? bus.dataToSave :
                  (32'(r1) < REGNUM) ? regs_q[r1] : '0;
        r2_data = (wr_hit && bus.writeAddress == r2) ? bus.dataToSave :
                  (32'(r2) < REGNUM) ? regs_q[r2] : '0;
        regs_d  = regs_q;
        if (wr_hit) begin
            regs_d[bus.writeAddress] = bus.dataToSave;
        end
    end

    always_comb begin
        hazard = idex_q.valid && (idex_q.opcode == LOADOPCODE) && bus.instrValid &&
                 ((idex_q.rd_addr == r1) || (idex_q.rd_addr == r2));
        bus.stallOut = reset && (hazard || bus.holdIn);
    end

    always_comb begin
        idex_d = idex_q;
        if (bus.flush) begin
            idex_d.valid = 1'b0;
        end else if (bus.holdIn) begin
            idex_d = idex_q;
        end else if (hazard) begin
            idex_d.valid = 1'b0;
        end else begin
            idex_d.valid   = bus.instrValid;
            idex_d.opcode  = opcode;
            idex_d.r1_data = r1_data;
            idex_d.r2_data = r2_data;
            idex_d.imm     = imm_ext;
            idex_d.r1_addr = r1;
            idex_d.r2_addr = r2;
            idex_d.rd_addr = rd;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
            for (int unsigned i = 0; i < REGNUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            idex_q <= idex_d;
            regs_q <= regs_d;
        end
    end

    always_comb begin
        bus.exValid       = idex_q.valid;
        bus.exOpcode      = idex_q.opcode;
        bus.exReg1Content = idex_q.r1_data;
        bus.exReg2Content = idex_q.r2_data;
        bus.exInmediate   = idex_q.imm;
        bus.exReg1Address = idex_q.r1_addr;
        bus.exReg2Address = idex_q.r2_addr;
        bus.exDestAddress = idex_q.rd_addr;
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (WIDTH=16): bypass, load-use, hold/flush, immediate, async reset.
module tb_decode_stage;
    logic clock;
    logic reset;
    int unsigned n_checks;
    int unsigned n_errors;

    decode_stage_if #(.WIDTH(16), .ADDRESSWIDTH(4), .OPCODEWIDTH(4), .INSTRUCTIONWIDTH(16)) bus ();

    decode_stage #(
        .WIDTH(16), .REGNUM(16), .ADDRESSWIDTH(4), .OPCODEWIDTH(4),
        .INSTRUCTIONWIDTH(16), .IMMWIDTH(8), .LOADOPCODE(4'h9)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [15:0] instr);
        bus.instrValid  = valid;
        bus.instruction = instr;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus.instrValid = 1'b0; bus.instruction = '0;
        bus.flush = 1'b0; bus.holdIn = 1'b1;
        bus.writeEnable = 1'b0; bus.writeAddress = '0; bus.dataToSave = '0;
        step(); step();
        check("rst_valid", 32'(bus.exValid), 0);
        check("rst_opcode", 32'(bus.exOpcode), 0);
        check("rst_stall_with_hold", 32'(bus.stallOut), 0);
        bus.holdIn = 1'b0;
        reset = 1'b1;

        // Bypass: write R3 while an instruction reads it
        bus.writeEnable = 1'b1; bus.writeAddress = 4'd3; bus.dataToSave = 16'h00A5;
        drive(1'b1, 16'h1230);
        step();
        bus.writeEnable = 1'b0;
        check("byp_valid", 32'(bus.exValid), 1);
        check("byp_opcode", 32'(bus.exOpcode), 1);
        check("byp_dest", 32'(bus.exDestAddress), 2);
        check("byp_r2addr", 32'(bus.exReg2Address), 3);
        check("byp_r1addr", 32'(bus.exReg1Address), 0);
        check("byp_r2data", 32'(bus.exReg2Content), 32'h00A5);
        check("byp_r1data", 32'(bus.exReg1Content), 0);
        check("byp_imm", 32'(bus.exInmediate), 32'h0030);

        // Stored value read back without bypass
        drive(1'b1, 16'h2534);
        step();
        check("rd_r2data", 32'(bus.exReg2Content), 32'h00A5);
        check("rd_r1data", 32'(bus.exReg1Content), 0);
        check("rd_dest", 32'(bus.exDestAddress), 5);

        // Non-load producer with matching dest: no stall
        drive(1'b1, 16'h3005);
        #1 check("nohaz_stall", 32'(bus.stallOut), 0);
        step();
        check("nohaz_valid", 32'(bus.exValid), 1);
        check("nohaz_opcode", 32'(bus.exOpcode), 3);

        // Load to R5 followed by consumer of R5
        drive(1'b1, 16'h9500);
        step();
        check("ld_opcode", 32'(bus.exOpcode), 9);
        drive(1'b1, 16'h4015);
        #1 check("lu_stall", 32'(bus.stallOut), 1);
        step();
        check("lu_bubble", 32'(bus.exValid), 0);
        check("lu_bubble_opc", 32'(bus.exOpcode), 9);
        check("lu_stall_clear", 32'(bus.stallOut), 0);
        step();
        check("lu_load_valid", 32'(bus.exValid), 1);
        check("lu_load_opcode", 32'(bus.exOpcode), 4);
        check("lu_load_r1", 32'(bus.exReg1Address), 5);

        // Hold freezes ID/EX; flush overrides hold
        bus.holdIn = 1'b1;
        drive(1'b1, 16'h7777);
        #1 check("hold_stall", 32'(bus.stallOut), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", 32'(bus.exValid), 1);
            check("hold_opcode", 32'(bus.exOpcode), 4);
            check("hold_dest", 32'(bus.exDestAddress), 0);
        end
        bus.flush = 1'b1;
        step();
        check("flush_valid", 32'(bus.exValid), 0);
        check("flush_opcode", 32'(bus.exOpcode), 4);
        bus.flush = 1'b0;
        bus.holdIn = 1'b0;

        // Immediate extension
        drive(1'b1, 16'h70F0);
        step();
        check("imm_opcode", 32'(bus.exOpcode), 7);
`ifdef DECODE_SIGNEXT_EN
        check("imm_ext", 32'(bus.exInmediate), 32'hFFF0);
`else
        check("imm_ext", 32'(bus.exInmediate), 32'h00F0);
`endif

        // instrValid low loads a bubble
        drive(1'b0, 16'h1111);
        step();
        check("inv_bubble", 32'(bus.exValid), 0);

        // Async reset in the middle of a load-use stall
        drive(1'b1, 16'h9600);
        step();
        drive(1'b1, 16'h4006);
        #1 check("rst_haz_stall", 32'(bus.stallOut), 1);
        bus.holdIn = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("arst_valid", 32'(bus.exValid), 0);
        check("arst_opcode", 32'(bus.exOpcode), 0);
        check("arst_dest", 32'(bus.exDestAddress), 0);
        check("arst_stall", 32'(bus.stallOut), 0);
        bus.writeEnable = 1'b1; bus.writeAddress = 4'd3; bus.dataToSave = 16'hFFFF;
        step();
        bus.writeEnable = 1'b0;
        bus.holdIn = 1'b0;
        reset = 1'b1;
        #1 check("post_rst_stall", 32'(bus.stallOut), 0);

        // Every register reads 0 after reset
        for (int unsigned i = 0; i < 16; i += 2) begin
            drive(1'b1, {4'h1, 4'h0, 4'(i + 1), 4'(i)});
            step();
            check("rf_clear_r1", 32'(bus.exReg1Content), 0);
            check("rf_clear_r2", 32'(bus.exReg2Content), 0);
            check("rf_clear_valid", 32'(bus.exValid), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
